reset_sequencer: RTL
====================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: the number of consecutive synchronized-lock cycles required before the peripheral reset is released.
REQ-002 SHALL have parameter PERIPH_HOLD_CYCLES, default 16: the number of cycles between peripheral reset release and CPU reset release.
REQ-003 SHALL have parameter BTN_HOLD_CYCLES, default 64: the number of cycles both resets are held after a reset-button pulse.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port pll_locked, input, 1 bit: raw PLL lock, asynchronous to clk.
REQ-007 SHALL have port reset_button, input, 1 bit: debounced button, single-cycle pulse, already synchronous to clk.
REQ-008 SHALL have port periph_rst, output, 1 bit: active-high reset for peripherals (UART, button parser).
REQ-009 SHALL have port cpu_rst, output, 1 bit: active-high reset for the CPU core.
REQ-010 SHALL have port ready, output, 1 bit: high only in state RUN.
REQ-011 SHALL have port seq_state, output, 2 bits: current state encoding.
REQ-012 SHALL have port lock_drop_cnt, output, 8 bits: saturating count of lock-loss events.

Function
REQ-013 SHALL pass pll_locked through a 2-flop synchronizer; sync_lock is the second flop output, and only sync_lock is used internally.
REQ-014 SHALL implement states LOCK_WAIT=0, PERIPH_WAIT=1, RUN=2, BTN_HOLD=3.
REQ-015 SHALL decode outputs as follows: periph_rst=1 in LOCK_WAIT and BTN_HOLD; cpu_rst=1 in every state except RUN; ready=1 only in RUN.
REQ-016 SHALL register all outputs, changing on the same edge as the state transition, with no combinational glitches.
REQ-017 LOCK_WAIT: the counter increments on each edge where sync_lock=1 and clears to 0 on any edge where sync_lock=0; on the LOCK_STABLE_CYCLES-th consecutive sync_lock=1 edge, the block goes to PERIPH_WAIT with the counter cleared.
REQ-018 PERIPH_WAIT: the counter increments each edge; on the PERIPH_HOLD_CYCLES-th edge, the block goes to RUN with the counter cleared.
REQ-019 RUN: the block remains in RUN until a lock loss or a reset_button pulse.
REQ-020 A reset_button pulse in RUN or PERIPH_WAIT SHALL go to BTN_HOLD with the counter cleared; in BTN_HOLD, on the BTN_HOLD_CYCLES-th edge, the block goes to PERIPH_WAIT (the lock wait is not repeated).
REQ-021 A reset_button pulse in LOCK_WAIT SHALL be ignored; a pulse in BTN_HOLD SHALL restart the BTN_HOLD count from 0.
REQ-022 sync_lock=0 in PERIPH_WAIT, RUN or BTN_HOLD SHALL go to LOCK_WAIT on that edge, clear the counter, and increment lock_drop_cnt, which saturates at 255 and never wraps.
REQ-023 When lock loss and a reset_button pulse occur on the same edge, lock loss SHALL win and BTN_HOLD SHALL not be entered.
REQ-024 The counter width SHALL be $clog2(max(LOCK_STABLE_CYCLES, PERIPH_HOLD_CYCLES, BTN_HOLD_CYCLES)+1), with no wrap before the terminal count.
REQ-025 All parameters SHALL be >= 1; a value of 1 means a single-cycle dwell.

Reset
REQ-026 When rst_n=0 at an edge, the block SHALL enter LOCK_WAIT and set counter=0, synchronizer flops=0, lock_drop_cnt=0, periph_rst=1, cpu_rst=1, ready=0, seq_state=0.
REQ-027 Reset asserted mid-sequence, in any state, SHALL take effect on that edge and override lock and button inputs.
REQ-028 There SHALL be no asynchronous reset path.

Verification (LOCK_STABLE_CYCLES=8, PERIPH_HOLD_CYCLES=4, BTN_HOLD_CYCLES=6)
REQ-029 Bench SHALL cover power-up: rst_n released, pll_locked=1 from edge 0 -> sync_lock high after edge 2; periph_rst falls after edge 10; cpu_rst falls and ready rises after edge 14; seq_state 0->1->2.
REQ-030 Bench SHALL cover a lock glitch: pll_locked low for 1 cycle at the 5th counting cycle in LOCK_WAIT -> counter restarts; periph_rst falls 8 sync-high edges after the glitch clears; lock_drop_cnt stays 0.
REQ-031 Bench SHALL cover a button press: a pulse in RUN -> both resets high the next cycle, seq_state=3; after 6 edges seq_state=1 with cpu_rst=1 and periph_rst=0; after 4 more edges, RUN.
REQ-032 Bench SHALL cover simultaneous events: a button pulse and lock drop on the same edge in RUN -> seq_state=0, lock_drop_cnt=1, BTN_HOLD never visited.
REQ-033 Bench SHALL cover saturation: 300 lock drops from RUN -> lock_drop_cnt=255.
REQ-034 Bench SHALL cover mid-sequence reset: rst_n=0 for 1 cycle during PERIPH_WAIT -> all REQ-026 values on the next cycle; the sequence restarts from LOCK_WAIT, including the 2-cycle synchronizer delay.

Source files
------------

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Power-on / recovery reset sequencer. It waits for the PLL lock to be stable
// for LOCK_STABLE_CYCLES cycles, releases the peripheral reset, waits
// PERIPH_HOLD_CYCLES more cycles, then releases the CPU reset and raises ready.
// A reset-button pulse after the lock wait holds both resets for
// BTN_HOLD_CYCLES cycles, then re-runs the peripheral-to-CPU stagger without
// repeating the lock wait. Losing lock anywhere past the lock wait sends the
// sequencer back to the lock wait and bumps a saturating lock-drop counter.
//
// Parameters (all must be >= 1; a value of 1 means a single-cycle dwell)
//   LOCK_STABLE_CYCLES  consecutive synchronized-lock cycles before periph release
//   PERIPH_HOLD_CYCLES  cycles between periph release and CPU release
//   BTN_HOLD_CYCLES     cycles both resets are held after a button pulse
//
// Ports
//   clk            in   single clock, all state on the rising edge
//   rst_n          in   synchronous active-low reset (no asynchronous path)
//   pll_locked     in   raw PLL lock, asynchronous to clk
//   reset_button   in   single-cycle pulse, already synchronous to clk
//   periph_rst     out  active-high peripheral reset (LOCK_WAIT, BTN_HOLD)
//   cpu_rst        out  active-high CPU reset (every state except RUN)
//   ready          out  high only in RUN
//   seq_state      out  current state encoding, doubles as the FSM debug view
//   lock_drop_cnt  out  saturating count of lock-loss events
//
// ready is a level status, not a handshake: it rises on the edge that enters
// RUN and falls on the edge that leaves it. There is no ready/valid pairing.
//
// All outputs come straight from flops. The output flops are loaded from the
// decode of the next state, so they change on the same edge as seq_state and
// cannot glitch.
// -----------------------------------------------------------------------------
module reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int PERIPH_HOLD_CYCLES = 16,
  parameter int BTN_HOLD_CYCLES    = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       reset_button,
  output logic       periph_rst,
  output logic       cpu_rst,
  output logic       ready,
  output logic [1:0] seq_state,
  output logic [7:0] lock_drop_cnt
);

  // ---------------------------------------------------------------------------
  // Dwell counter sizing: wide enough to hold the largest terminal count, so
  // the counter can never wrap before its terminal count is reached.
  // ---------------------------------------------------------------------------
  localparam int MAX_AB  = (LOCK_STABLE_CYCLES > PERIPH_HOLD_CYCLES) ?
                           LOCK_STABLE_CYCLES : PERIPH_HOLD_CYCLES;
  localparam int MAX_CYC = (MAX_AB > BTN_HOLD_CYCLES) ? MAX_AB : BTN_HOLD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // The counter holds the number of qualifying edges already seen in the
  // current state, so the N-th edge is the one where the counter reads N-1.
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PERIPH_LAST = CNT_W'(PERIPH_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BTN_LAST    = CNT_W'(BTN_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  localparam logic [7:0] DROP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    ST_LOCK_WAIT   = 2'd0,
    ST_PERIPH_WAIT = 2'd1,
    ST_RUN         = 2'd2,
    ST_BTN_HOLD    = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic             sync_meta_q;    // first synchronizer flop, may go metastable
  logic             sync_lock_q;    // second synchronizer flop, the only lock used
  state_e           state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [7:0]       drop_q,       drop_d;
  logic             periph_rst_q, periph_rst_d;
  logic             cpu_rst_q,    cpu_rst_d;
  logic             ready_q,      ready_d;

  // ---------------------------------------------------------------------------
  // Lock synchronizer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_meta_q <= 1'b0;
      sync_lock_q <= 1'b0;
    end else begin
      sync_meta_q <= pll_locked;
      sync_lock_q <= sync_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // State, counter, drop counter and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_LOCK_WAIT;
      cnt_q        <= CNT_ZERO;
      drop_q       <= 8'd0;
      periph_rst_q <= 1'b1;
      cpu_rst_q    <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      drop_q       <= drop_d;
      periph_rst_q <= periph_rst_d;
      cpu_rst_q    <= cpu_rst_d;
      ready_q      <= ready_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  //
  // Priority past the lock wait: lock loss, then button, then dwell expiry.
  // Lock loss beating the button means a simultaneous pair never visits
  // BTN_HOLD. A button pulse in BTN_HOLD simply re-enters it with a cleared
  // counter, which restarts the hold.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;

    unique case (state_q)
      ST_LOCK_WAIT: begin
        // Button pulses are ignored here; only lock stability matters.
        if (!sync_lock_q) begin
          cnt_d = CNT_ZERO;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = ST_PERIPH_WAIT;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_PERIPH_WAIT, ST_RUN, ST_BTN_HOLD: begin
        if (!sync_lock_q) begin
          state_d = ST_LOCK_WAIT;
          cnt_d   = CNT_ZERO;
          if (drop_q != DROP_MAX) begin
            drop_d = drop_q + 8'd1;
          end
        end else if (reset_button) begin
          state_d = ST_BTN_HOLD;
          cnt_d   = CNT_ZERO;
        end else if (state_q == ST_PERIPH_WAIT) begin
          if (cnt_q == PERIPH_LAST) begin
            state_d = ST_RUN;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else if (state_q == ST_BTN_HOLD) begin
          // Lock wait is not repeated after a button hold: the PLL is still
          // locked, so only the stagger is re-run.
          if (cnt_q == BTN_LAST) begin
            state_d = ST_PERIPH_WAIT;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        // ST_RUN with lock held and no button: stay, counter untouched.
      end

      default: begin
        state_d = ST_LOCK_WAIT;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode from the next state, registered above
  // ---------------------------------------------------------------------------
  always_comb begin
    periph_rst_d = 1'b1;
    cpu_rst_d    = 1'b1;
    ready_d      = 1'b0;

    unique case (state_d)
      ST_LOCK_WAIT: begin
        periph_rst_d = 1'b1;
        cpu_rst_d    = 1'b1;
      end
      ST_PERIPH_WAIT: begin
        periph_rst_d = 1'b0;
        cpu_rst_d    = 1'b1;
      end
      ST_RUN: begin
        periph_rst_d = 1'b0;
        cpu_rst_d    = 1'b0;
        ready_d      = 1'b1;
      end
      ST_BTN_HOLD: begin
        periph_rst_d = 1'b1;
        cpu_rst_d    = 1'b1;
      end
      default: begin
        periph_rst_d = 1'b1;
        cpu_rst_d    = 1'b1;
        ready_d      = 1'b0;
      end
    endcase
  end

  assign periph_rst    = periph_rst_q;
  assign cpu_rst       = cpu_rst_q;
  assign ready         = ready_q;
  assign seq_state     = state_q;
  assign lock_drop_cnt = drop_q;

endmodule
